// File: rtl/sys_cntr_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sys_cntr_tx : serialises register-read bytes and 2-byte ALU results into
//               the Tx FIFO with round-robin arbitration.      Rev 1.0
// ---------------------------------------------------------------------------
module sys_cntr_tx #(
  parameter int width = 8
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [width-1:0]   RdData,
  input  logic               RdData_Valid,
  input  logic [2*width-1:0] ALU_OUT,
  input  logic               OUT_Valid,
  input  logic               FIFO_Full,
  output logic               WR_INC,
  output logic [width-1:0]   WR_DATA,
  output logic               Busy,
  output logic               Overrun
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND_RD     = 2'd1,
    SEND_ALU_LO = 2'd2,
    SEND_ALU_HI = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [width-1:0]   rd_buf_q, rd_buf_d;
  logic [2*width-1:0] alu_buf_q, alu_buf_d;
  logic               rd_pend_q, rd_pend_d;
  logic               alu_pend_q, alu_pend_d;
  logic               overrun_q, overrun_d;

  logic push, rd_clr, alu_clr;

  always_comb begin
    push    = (state_q != IDLE) && !FIFO_Full;
    rd_clr  = push && (state_q == SEND_RD);
    alu_clr = push && (state_q == SEND_ALU_HI);

    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rd_pend_q)       state_d = SEND_RD;
        else if (alu_pend_q) state_d = SEND_ALU_LO;
      end
      SEND_RD:     if (push) state_d = alu_pend_q ? SEND_ALU_LO : IDLE;
      SEND_ALU_LO: if (push) state_d = SEND_ALU_HI;
      SEND_ALU_HI: if (push) state_d = rd_pend_q ? SEND_RD : IDLE;
      default:     state_d = IDLE;
    endcase

    // A strobe on the clearing edge refills the buffer and keeps the flag set.
    rd_buf_d  = rd_buf_q;
    rd_pend_d = rd_pend_q && !rd_clr;
    if (RdData_Valid && (!rd_pend_q || rd_clr)) begin
      rd_buf_d  = RdData;
      rd_pend_d = 1'b1;
    end

    alu_buf_d  = alu_buf_q;
    alu_pend_d = alu_pend_q && !alu_clr;
    if (OUT_Valid && (!alu_pend_q || alu_clr)) begin
      alu_buf_d  = ALU_OUT;
      alu_pend_d = 1'b1;
    end

    overrun_d = (RdData_Valid && rd_pend_q && !rd_clr) ||
                (OUT_Valid && alu_pend_q && !alu_clr);
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      rd_buf_q   <= '0;
      alu_buf_q  <= '0;
      rd_pend_q  <= 1'b0;
      alu_pend_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_buf_q   <= rd_buf_d;
      alu_buf_q  <= alu_buf_d;
      rd_pend_q  <= rd_pend_d;
      alu_pend_q <= alu_pend_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    WR_DATA = '0;
    case (state_q)
      SEND_RD:     WR_DATA = rd_buf_q;
      SEND_ALU_LO: WR_DATA = alu_buf_q[width-1:0];
      SEND_ALU_HI: WR_DATA = alu_buf_q[2*width-1:width];
      default:     WR_DATA = '0;
    endcase
  end

  assign WR_INC  = push;
  assign Busy    = (state_q != IDLE) || rd_pend_q || alu_pend_q;
  assign Overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_sys_cntr_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_sys_cntr_tx : directed self-checking bench for sys_cntr_tx.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_sys_cntr_tx;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic [7:0]  RdData = '0;
  logic        RdData_Valid = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        OUT_Valid = 1'b0;
  logic        FIFO_Full = 1'b0;
  logic        WR_INC;
  logic [7:0]  WR_DATA;
  logic        Busy;
  logic        Overrun;

  int n_assert = 0;
  int n_fail   = 0;

  sys_cntr_tx #(.width(8)) dut (
    .CLK(CLK), .Reset(Reset),
    .RdData(RdData), .RdData_Valid(RdData_Valid),
    .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid),
    .FIFO_Full(FIFO_Full),
    .WR_INC(WR_INC), .WR_DATA(WR_DATA), .Busy(Busy), .Overrun(Overrun)
  );

  always #5 CLK = ~CLK;

  // Advance one clock; inputs are then driven 1ns after the rising edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check all four outputs after letting combinational logic settle.
  task automatic chk_all(input string tag, input logic inc, input logic [7:0] data,
                         input logic busy, input logic ovr);
    #1;
    chk({tag, ".WR_INC"},  {15'd0, WR_INC},  {15'd0, inc});
    chk({tag, ".WR_DATA"}, {8'd0, WR_DATA},  {8'd0, data});
    chk({tag, ".Busy"},    {15'd0, Busy},    {15'd0, busy});
    chk({tag, ".Overrun"}, {15'd0, Overrun}, {15'd0, ovr});
  endtask

  initial begin
    // Reset state
    #2;
    chk_all("reset", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(); cyc();
    Reset = 1'b1;
    cyc();
    chk_all("post_reset", 1'b0, 8'h00, 1'b0, 1'b0);

    // Single register read byte
    RdData = 8'h5A; RdData_Valid = 1'b1;
    cyc(); RdData_Valid = 1'b0;
    chk_all("rd.capture", 1'b0, 8'h00, 1'b1, 1'b0);
    cyc();
    chk_all("rd.push", 1'b1, 8'h5A, 1'b1, 1'b0);
    cyc();
    chk_all("rd.done", 1'b0, 8'h00, 1'b0, 1'b0);

    // ALU result: low byte then high byte
    cyc();
    ALU_OUT = 16'h1234; OUT_Valid = 1'b1;
    cyc(); OUT_Valid = 1'b0;
    chk_all("alu.capture", 1'b0, 8'h00, 1'b1, 1'b0);
    cyc();
    chk_all("alu.lo", 1'b1, 8'h34, 1'b1, 1'b0);
    cyc();
    chk_all("alu.hi", 1'b1, 8'h12, 1'b1, 1'b0);
    cyc();
    chk_all("alu.done", 1'b0, 8'h00, 1'b0, 1'b0);

    // Simultaneous capture: read byte first, then ALU pair
    RdData = 8'hA1; RdData_Valid = 1'b1;
    ALU_OUT = 16'hBEEF; OUT_Valid = 1'b1;
    cyc(); RdData_Valid = 1'b0; OUT_Valid = 1'b0;
    chk_all("sim.capture", 1'b0, 8'h00, 1'b1, 1'b0);
    cyc();
    chk_all("sim.rd", 1'b1, 8'hA1, 1'b1, 1'b0);
    cyc();
    chk_all("sim.lo", 1'b1, 8'hEF, 1'b1, 1'b0);
    cyc();
    chk_all("sim.hi", 1'b1, 8'hBE, 1'b1, 1'b0);
    cyc();
    chk_all("sim.done", 1'b0, 8'h00, 1'b0, 1'b0);

    // Back-pressure during the high byte of 0x00FF
    ALU_OUT = 16'h00FF; OUT_Valid = 1'b1;
    cyc(); OUT_Valid = 1'b0;
    cyc();
    chk_all("bp.lo", 1'b1, 8'hFF, 1'b1, 1'b0);
    cyc();
    FIFO_Full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk_all("bp.hold", 1'b0, 8'h00, 1'b1, 1'b0);
      if (i < 4) cyc();
    end
    FIFO_Full = 1'b0;
    chk_all("bp.hi", 1'b1, 8'h00, 1'b1, 1'b0);
    cyc();
    chk_all("bp.done", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc();
    chk_all("bp.nodup", 1'b0, 8'h00, 1'b0, 1'b0);

    // Overrun: second read while first is stuck behind a full FIFO
    FIFO_Full = 1'b1;
    RdData = 8'h5A; RdData_Valid = 1'b1;
    cyc();
    RdData = 8'h77;
    chk_all("ovr.first", 1'b0, 8'h00, 1'b1, 1'b0);
    cyc(); RdData_Valid = 1'b0;
    chk_all("ovr.pulse", 1'b0, 8'h5A, 1'b1, 1'b1);
    cyc();
    chk_all("ovr.end", 1'b0, 8'h5A, 1'b1, 1'b0);
    FIFO_Full = 1'b0;
    chk_all("ovr.push", 1'b1, 8'h5A, 1'b1, 1'b0);
    cyc();
    chk_all("ovr.done", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc();
    chk_all("ovr.nodrop", 1'b0, 8'h00, 1'b0, 1'b0);

    // Reset in the middle of an ALU pair
    ALU_OUT = 16'h1234; OUT_Valid = 1'b1;
    cyc(); OUT_Valid = 1'b0;
    cyc();
    chk_all("rst.lo", 1'b1, 8'h34, 1'b1, 1'b0);
    cyc();
    Reset = 1'b0;
    chk_all("rst.async", 1'b0, 8'h00, 1'b0, 1'b0);
    cyc();
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_all("rst.nopush", 1'b0, 8'h00, 1'b0, 1'b0);
    end

    // Capture resumes after reset
    RdData = 8'h3C; RdData_Valid = 1'b1;
    cyc(); RdData_Valid = 1'b0;
    chk_all("resume.capture", 1'b0, 8'h00, 1'b1, 1'b0);
    cyc();
    chk_all("resume.push", 1'b1, 8'h3C, 1'b1, 1'b0);
    cyc();
    chk_all("resume.done", 1'b0, 8'h00, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sys_cntr_tx.md
SYS_CNTR_TX -- requirements
Module: sys_cntr_tx

Interface
REQ-001 SHALL have parameter width, default 8, meaning byte width of register-file read data and Tx FIFO data.
REQ-002 SHALL have input CLK, 1 bit, system clock; all state changes on its rising edge.
REQ-003 SHALL have input Reset, 1 bit, asynchronous, active-low reset.
REQ-004 SHALL have input RdData, width bits, register-file read data.
REQ-005 SHALL have input RdData_Valid, 1 bit, one-cycle strobe qualifying RdData.
REQ-006 SHALL have input ALU_OUT, 2*width bits, ALU result.
REQ-007 SHALL have input OUT_Valid, 1 bit, one-cycle strobe qualifying ALU_OUT.
REQ-008 SHALL have input FIFO_Full, 1 bit, Tx FIFO cannot accept a push this cycle.
REQ-009 SHALL have output WR_INC, 1 bit, Tx FIFO push strobe.
REQ-010 SHALL have output WR_DATA, width bits, byte presented to the Tx FIFO.
REQ-011 SHALL have output Busy, 1 bit, block holds or is sending data.
REQ-012 SHALL have output Overrun, 1 bit, one-cycle pulse when an incoming result is dropped.

Function
REQ-013 SHALL hold one pending register-read byte (rd_buf, rd_pend) and one pending ALU result (alu_buf, alu_pend).
REQ-014 SHALL, on a rising edge with RdData_Valid=1 and rd_pend=0, load rd_buf<=RdData and set rd_pend; OUT_Valid likewise loads alu_buf and sets alu_pend.
REQ-015 SHALL capture both sources on the same edge when both strobes are high.
REQ-016 SHALL, when a strobe arrives while its pending flag is set and not being cleared that edge, drop the new data, keep the buffer unchanged and pulse Overrun high for the next cycle.
REQ-017 SHALL, when a strobe arrives on the edge its pending flag is cleared, capture the new data and leave the flag set (no Overrun).
REQ-018 SHALL implement states IDLE, SEND_RD, SEND_ALU_LO, SEND_ALU_HI.
REQ-019 SHALL in IDLE go to SEND_RD if rd_pend, else to SEND_ALU_LO if alu_pend, else stay in IDLE.
REQ-020 SHALL, in any SEND state with FIFO_Full=1, hold state, keep WR_DATA stable and keep WR_INC=0.
REQ-021 SHALL drive WR_INC = (state is a SEND state) AND NOT FIFO_Full, combinationally; each WR_INC cycle is exactly one byte push.
REQ-022 SHALL drive WR_DATA = rd_buf in SEND_RD, alu_buf[width-1:0] in SEND_ALU_LO, alu_buf[2*width-1:width] in SEND_ALU_HI, and 0 in IDLE.
REQ-023 SHALL, on a push in SEND_RD, clear rd_pend and go to SEND_ALU_LO if alu_pend, else IDLE.
REQ-024 SHALL, on a push in SEND_ALU_LO, go to SEND_ALU_HI.
REQ-025 SHALL, on a push in SEND_ALU_HI, clear alu_pend and go to SEND_RD if rd_pend, else IDLE (round-robin fairness).
REQ-026 SHALL send the ALU low byte before the high byte, never splitting or interleaving the two bytes with a register-read byte.
REQ-027 SHALL assert WR_INC first two cycles after the capture edge when idle and FIFO not full (capture edge, then IDLE decision edge).
REQ-028 SHALL drive Busy = (state != IDLE) OR rd_pend OR alu_pend.

Reset
REQ-029 SHALL, on Reset low, immediately force state IDLE, rd_pend=0, alu_pend=0, rd_buf=0, alu_buf=0, Overrun=0, hence WR_INC=0, WR_DATA=0, Busy=0.
REQ-030 SHALL discard any pending or partially sent result when Reset asserts mid-operation; no further pushes for that result after release.
REQ-031 SHALL resume normal capture on the first rising edge after Reset deasserts.

Verification
REQ-032 Read: RdData=0x5A with RdData_Valid pulse, FIFO_Full=0 -> single WR_INC with WR_DATA=0x5A two cycles later, then Busy=0.
REQ-033 ALU: ALU_OUT=0x1234 with OUT_Valid pulse -> WR_INC on two consecutive cycles, WR_DATA 0x34 then 0x12.
REQ-034 Simultaneous: RdData=0xA1 and ALU_OUT=0xBEEF on same cycle -> pushes 0xA1, 0xEF, 0xBE in order, no Overrun.
REQ-035 Back-pressure: FIFO_Full=1 for 5 cycles during SEND_ALU_HI of 0x00FF -> WR_INC=0 and WR_DATA=0x00 held; one push of 0x00 after FIFO_Full falls, no duplication.
REQ-036 Overrun: second RdData_Valid (0x77) while 0x5A is pending under FIFO_Full=1 -> Overrun pulses one cycle; only 0x5A is pushed.
REQ-037 Reset mid-send: Reset low after 0x34 push of 0x1234 -> all outputs 0 immediately; 0x12 never pushed after release.
